bram_sdp_param: RTL and testbench
=================================

Name: bram_sdp_param

Overview:
- Parametrised simple-dual-port behavioural BRAM model; the next generation of the FIR tap and data-buffer RAMs.
- Port A is write-only with per-byte enables. Port B is read-only, with a registered read of 1 or 2 cycles and a valid strobe.
- Adds an asynchronous active-low reset, a post-reset clear sweep with a ready flag, configurable read/write collision behaviour, and out-of-range write detection.
- Instanced by the FIR engine for tap and data storage; FIR control must wait for init_done before issuing accesses.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 11, number of words.
- ADDR_W, 12, byte-address width; word index = addr >> log2(DATA_W/8).
- RD_LATENCY, 1, cycles from rd_en to rd_valid/rd_data; legal values 1 or 2.
- WRITE_FIRST, 0, same-word collision: 0 = read returns old word; 1 = read returns newly merged word.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset release; 0 = contents preserved.

Ports:
- axis_clk  in  1  clock; all logic on rising edge.
- axis_rst_n  in  1  reset, asynchronous assert, active-low.
- wr_en  in  1  write request, port A.
- wr_be  in  DATA_W/8  byte enables; bit i selects byte i.
- wr_addr  in  ADDR_W  byte address, port A.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request, port B.
- rd_addr  in  ADDR_W  byte address, port B.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  single-cycle strobe marking rd_data valid.
- init_done  out  1  1 = RAM accepts accesses.
- wr_oor  out  1  sticky flag: an out-of-range write was attempted.

Behaviour:
- Reset (axis_rst_n = 0, any cycle, takes effect immediately):
  - rd_data = 0, rd_valid = 0, init_done = 0, wr_oor = 0.
  - Read pipeline flushed; clear counter = 0.
  - FSM enters CLEAR if CLEAR_ON_RESET = 1, otherwise READY.
- FSM CLEAR:
  - Writes 0 to word clr_cnt each cycle; clr_cnt increments 0..DEPTH-1.
  - After writing word DEPTH-1, moves to READY; init_done = 1 from the next cycle. CLEAR therefore lasts exactly DEPTH cycles after reset release.
  - wr_en and rd_en are ignored (no write, no rd_valid).
- FSM READY:
  - Stays in READY until reset; init_done = 1.
- Write (READY, wr_en = 1, word index < DEPTH):
  - Only bytes with wr_be[i] = 1 are updated at the clock edge; other bytes keep their value.
  - wr_be = 0 is a legal no-op.
- Out-of-range write (READY, wr_en = 1, word index >= DEPTH):
  - Memory unchanged; wr_oor set to 1 and held until reset.
- Read (READY, rd_en = 1):
  - RD_LATENCY = 1: rd_data and rd_valid update at the edge after rd_en is sampled.
  - RD_LATENCY = 2: one extra register stage, so they update one edge later.
  - Back-to-back reads give one result per cycle, in order.
  - Word index >= DEPTH returns 0 with rd_valid = 1; wr_oor is not affected.
- rd_data holds its last value when no read completes; rd_valid = 0 in those cycles.
- Collision (wr_en and rd_en in the same cycle, same word):
  - WRITE_FIRST = 0: the read returns the pre-write word.
  - WRITE_FIRST = 1: the read returns the byte-merged post-write word.
  - Different words: no interaction.
- Reset mid-operation:
  - In-flight reads are discarded; no rd_valid is produced for them.
  - A clear sweep interrupted by reset restarts from word 0.
  - With CLEAR_ON_RESET = 0, contents survive reset.

Test Plan:
- Clear sweep. Release reset with DEPTH = 11, CLEAR_ON_RESET = 1 -> init_done rises exactly 11 cycles after release; a read of every address returns 0x00000000.
- Byte enables. Write 0xAABBCCDD with wr_be = 4'b1111 to addr 0x08, then 0x11223344 with wr_be = 4'b0101 to the same address -> read returns 0xAA22CC44 with rd_valid 1 cycle after rd_en (RD_LATENCY = 1).
- Collision. Word 3 holds 0x00000005; in the same cycle write 0x00000009 (wr_be = 4'b1111) to addr 0x0C and read addr 0x0C -> WRITE_FIRST = 0 returns 0x00000005; WRITE_FIRST = 1 returns 0x00000009.
- Streaming with RD_LATENCY = 2. Read addr 0x00, 0x04, 0x08 on consecutive cycles -> three consecutive rd_valid pulses starting 2 cycles after the first rd_en, data in address order.
- Out of range. Write to addr 0x2C (word 11, DEPTH = 11) -> wr_oor = 1 and stays 1; all 11 words unchanged; a read of 0x2C returns 0 with rd_valid.
- Reset mid-operation. Assert axis_rst_n = 0 for 1 cycle while a read is in flight and the sweep is at word 5 -> no rd_valid for the in-flight read; wr_oor = 0; init_done = 0 immediately; sweep restarts and init_done rises 11 cycles after release.

Source files
------------

// File: rtl/bram_sdp_param.sv
// Simple-dual-port behavioural BRAM: byte-enabled write port, pipelined read port,
// post-reset clear sweep, configurable collision policy and out-of-range write flag.
module bram_sdp_param #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 11,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned RD_LATENCY     = 1,
    parameter bit          WRITE_FIRST    = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                axis_clk,
    input  logic                axis_rst_n,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                init_done,
    output logic                wr_oor
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFFS  = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  clr_cnt_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_word;
    logic [ADDR_W-1:0] rd_word;
    logic              ready;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_fire;
    logic              wr_bad;
    logic              rd_fire;
    logic [DATA_W-1:0] rd_old;
    logic [DATA_W-1:0] rd_new;

    assign wr_word     = wr_addr >> OFFS;
    assign rd_word     = rd_addr >> OFFS;
    assign ready       = (state_q == StReady);
    assign wr_in_range = (wr_word < ADDR_W'(DEPTH));
    assign rd_in_range = (rd_word < ADDR_W'(DEPTH));
    assign wr_fire     = ready && wr_en && wr_in_range;
    assign wr_bad      = ready && wr_en && !wr_in_range;
    assign rd_fire     = ready && rd_en;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q   <= CLEAR_ON_RESET ? StClear : StReady;
            clr_cnt_q <= '0;
            init_done <= 1'b0;
            wr_oor    <= 1'b0;
        end else begin
            case (state_q)
                StClear: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q   <= StReady;
                        init_done <= 1'b1;
                    end
                end
                StReady: begin
                    init_done <= 1'b1;
                    if (wr_bad) begin
                        wr_oor <= 1'b1;
                    end
                end
                default: state_q <= StReady;
            endcase
        end
    end

    // Storage has no reset so contents can survive it; the sweep is held off while in reset.
    always_ff @(posedge axis_clk) begin
        if (axis_rst_n && state_q == StClear) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_word[IDX_W-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_old = '0;
        if (rd_in_range) begin
            rd_old = mem[rd_word[IDX_W-1:0]];
        end
        rd_new = rd_old;
        if (WRITE_FIRST && wr_fire && (wr_word == rd_word)) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wr_be[i]) begin
                    rd_new[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) begin
                s1_data_q <= rd_new;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic              s2_valid_q;
        logic [DATA_W-1:0] s2_data_q;

        always_ff @(posedge axis_clk or negedge axis_rst_n) begin
            if (!axis_rst_n) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign rd_valid = s2_valid_q;
        assign rd_data  = s2_data_q;
    end else begin : g_lat1
        assign rd_valid = s1_valid_q;
        assign rd_data  = s1_data_q;
    end

endmodule

// File: tb/tb_bram_sdp_param.sv
// Directed bench: two instances (latency 1 / read-first and latency 2 / write-first)
// share all stimulus; each scenario task checks both against hand-computed values.
module tb_bram_sdp_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [11:0] rd_addr;

    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        init_done0, init_done1;
    logic        wr_oor0, wr_oor1;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_mem [11];

    always #5 clk = ~clk;

    bram_sdp_param #(
        .DATA_W(32), .DEPTH(11), .ADDR_W(12),
        .RD_LATENCY(1), .WRITE_FIRST(1'b0), .CLEAR_ON_RESET(1'b1)
    ) u_dut0 (
        .axis_clk(clk), .axis_rst_n(rst_n),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .init_done(init_done0), .wr_oor(wr_oor0)
    );

    bram_sdp_param #(
        .DATA_W(32), .DEPTH(11), .ADDR_W(12),
        .RD_LATENCY(2), .WRITE_FIRST(1'b1), .CLEAR_ON_RESET(1'b1)
    ) u_dut1 (
        .axis_clk(clk), .axis_rst_n(rst_n),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .init_done(init_done1), .wr_oor(wr_oor1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic rd_pulse(input logic [11:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_be = '0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        #1;
        step();
        step();
        n_vec++;
        if ({rd_valid0, init_done0, wr_oor0, rd_data0} !== 35'd0) begin
            $display("FAIL reset_dut0: got v=%b id=%b oor=%b d=%h, want all 0",
                     rd_valid0, init_done0, wr_oor0, rd_data0);
            n_err++;
        end
        n_vec++;
        if ({rd_valid1, init_done1, wr_oor1, rd_data1} !== 35'd0) begin
            $display("FAIL reset_dut1: got v=%b id=%b oor=%b d=%h, want all 0",
                     rd_valid1, init_done1, wr_oor1, rd_data1);
            n_err++;
        end
    endtask

    task automatic test_clear_sweep();
        rst_n = 1'b1;
        // Accesses during the sweep must be ignored.
        wr_en = 1'b1; wr_addr = 12'h008; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 12'h008;
        for (int k = 1; k <= 11; k++) begin
            step();
            n_vec++;
            if (init_done0 !== (k == 11) || init_done1 !== (k == 11)) begin
                $display("FAIL clear_init_done cyc %0d: got %b/%b, want %b",
                         k, init_done0, init_done1, (k == 11));
                n_err++;
            end
            n_vec++;
            if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
                $display("FAIL clear_rd_gated cyc %0d: got %b/%b, want 0/0", k, rd_valid0, rd_valid1);
                n_err++;
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        step();
        n_vec++;
        if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
            $display("FAIL clear_last_rd_gated: got %b/%b, want 0/0", rd_valid0, rd_valid1);
            n_err++;
        end
        for (int k = 0; k <= 11; k++) begin
            if (k < 11) begin
                rd_en   = 1'b1;
                rd_addr = 12'(k * 4);
            end else begin
                rd_en = 1'b0;
            end
            step();
            n_vec++;
            if ({rd_valid0, rd_data0} !== {(k < 11), 32'h0}) begin
                $display("FAIL clear_read0 k=%0d: got v=%b d=%h, want v=%b d=0",
                         k, rd_valid0, rd_data0, (k < 11));
                n_err++;
            end
            n_vec++;
            if ({rd_valid1, rd_data1} !== {(k > 0), 32'h0}) begin
                $display("FAIL clear_read1 k=%0d: got v=%b d=%h, want v=%b d=0",
                         k, rd_valid1, rd_data1, (k > 0));
                n_err++;
            end
        end
        step();
    endtask

    task automatic test_byte_enables();
        wr(12'h008, 32'hAABBCCDD, 4'b1111);
        wr(12'h008, 32'h11223344, 4'b0101);
        rd_pulse(12'h008);
        n_vec++;
        if ({rd_valid0, rd_data0} !== {1'b1, 32'hAA22CC44}) begin
            $display("FAIL be_read0: got v=%b d=%h, want v=1 d=aa22cc44", rd_valid0, rd_data0);
            n_err++;
        end
        n_vec++;
        if (rd_valid1 !== 1'b0) begin
            $display("FAIL be_lat2_early: got v=%b, want 0", rd_valid1);
            n_err++;
        end
        step();
        n_vec++;
        if ({rd_valid1, rd_data1} !== {1'b1, 32'hAA22CC44}) begin
            $display("FAIL be_read1: got v=%b d=%h, want v=1 d=aa22cc44", rd_valid1, rd_data1);
            n_err++;
        end
        n_vec++;
        if ({rd_valid0, rd_data0} !== {1'b0, 32'hAA22CC44}) begin
            $display("FAIL be_hold0: got v=%b d=%h, want v=0 d=aa22cc44", rd_valid0, rd_data0);
            n_err++;
        end
        wr(12'h008, 32'hFFFFFFFF, 4'b0000);
        rd_pulse(12'h008);
        n_vec++;
        if ({rd_valid0, rd_data0} !== {1'b1, 32'hAA22CC44}) begin
            $display("FAIL be_zero_noop0: got v=%b d=%h, want v=1 d=aa22cc44", rd_valid0, rd_data0);
            n_err++;
        end
        step();
        n_vec++;
        if ({rd_valid1, rd_data1} !== {1'b1, 32'hAA22CC44}) begin
            $display("FAIL be_zero_noop1: got v=%b d=%h, want v=1 d=aa22cc44", rd_valid1, rd_data1);
            n_err++;
        end
    endtask

    task automatic test_collision();
        wr(12'h00C, 32'h00000005, 4'b1111);
        wr_en = 1'b1; wr_addr = 12'h00C; wr_data = 32'h00000009; wr_be = 4'b1111;
        rd_en = 1'b1; rd_addr = 12'h00C;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        n_vec++;
        if ({rd_valid0, rd_data0} !== {1'b1, 32'h00000005}) begin
            $display("FAIL coll_read_first: got v=%b d=%h, want v=1 d=00000005", rd_valid0, rd_data0);
            n_err++;
        end
        step();
        n_vec++;
        if ({rd_valid1, rd_data1} !== {1'b1, 32'h00000009}) begin
            $display("FAIL coll_write_first: got v=%b d=%h, want v=1 d=00000009", rd_valid1, rd_data1);
            n_err++;
        end
        // Partial-byte collision: write-first must merge into the old word.
        wr_en = 1'b1; wr_addr = 12'h00C; wr_data = 32'h0000AB00; wr_be = 4'b0010;
        rd_en = 1'b1; rd_addr = 12'h00C;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        n_vec++;
        if ({rd_valid0, rd_data0} !== {1'b1, 32'h00000009}) begin
            $display("FAIL coll_part_rf: got v=%b d=%h, want v=1 d=00000009", rd_valid0, rd_data0);
            n_err++;
        end
        step();
        n_vec++;
        if ({rd_valid1, rd_data1} !== {1'b1, 32'h0000AB09}) begin
            $display("FAIL coll_part_wf: got v=%b d=%h, want v=1 d=0000ab09", rd_valid1, rd_data1);
            n_err++;
        end
        // Different words in the same cycle do not interact.
        wr_en = 1'b1; wr_addr = 12'h010; wr_data = 32'h00000077; wr_be = 4'b1111;
        rd_en = 1'b1; rd_addr = 12'h00C;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        n_vec++;
        if ({rd_valid0, rd_data0} !== {1'b1, 32'h0000AB09}) begin
            $display("FAIL coll_diff0: got v=%b d=%h, want v=1 d=0000ab09", rd_valid0, rd_data0);
            n_err++;
        end
        step();
        n_vec++;
        if ({rd_valid1, rd_data1} !== {1'b1, 32'h0000AB09}) begin
            $display("FAIL coll_diff1: got v=%b d=%h, want v=1 d=0000ab09", rd_valid1, rd_data1);
            n_err++;
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp [3];
        exp[0] = 32'h10101010;
        exp[1] = 32'h20202020;
        exp[2] = 32'hAA22CC44;
        wr(12'h000, 32'h10101010, 4'b1111);
        wr(12'h004, 32'h20202020, 4'b1111);
        for (int k = 0; k <= 4; k++) begin
            if (k < 3) begin
                rd_en   = 1'b1;
                rd_addr = 12'(k * 4);
            end else begin
                rd_en = 1'b0;
            end
            step();
            n_vec++;
            if ({rd_valid0, rd_data0} !== {(k < 3), exp[(k < 3) ? k : 2]}) begin
                $display("FAIL stream0 k=%0d: got v=%b d=%h, want v=%b d=%h",
                         k, rd_valid0, rd_data0, (k < 3), exp[(k < 3) ? k : 2]);
                n_err++;
            end
            n_vec++;
            if (k == 0) begin
                if (rd_valid1 !== 1'b0) begin
                    $display("FAIL stream1 k=0: got v=%b, want v=0", rd_valid1);
                    n_err++;
                end
            end else if ({rd_valid1, rd_data1} !== {(k < 4), exp[(k < 4) ? k - 1 : 2]}) begin
                $display("FAIL stream1 k=%0d: got v=%b d=%h, want v=%b d=%h",
                         k, rd_valid1, rd_data1, (k < 4), exp[(k < 4) ? k - 1 : 2]);
                n_err++;
            end
        end
    endtask

    task automatic test_oor();
        for (int i = 0; i < 11; i++) begin
            exp_mem[i] = 32'h0;
        end
        exp_mem[0] = 32'h10101010;
        exp_mem[1] = 32'h20202020;
        exp_mem[2] = 32'hAA22CC44;
        exp_mem[3] = 32'h0000AB09;
        exp_mem[4] = 32'h00000077;
        rd_pulse(12'h02C);
        n_vec++;
        if ({rd_valid0, rd_data0} !== {1'b1, 32'h0}) begin
            $display("FAIL oor_read0: got v=%b d=%h, want v=1 d=0", rd_valid0, rd_data0);
            n_err++;
        end
        step();
        n_vec++;
        if ({rd_valid1, rd_data1} !== {1'b1, 32'h0}) begin
            $display("FAIL oor_read1: got v=%b d=%h, want v=1 d=0", rd_valid1, rd_data1);
            n_err++;
        end
        n_vec++;
        if (wr_oor0 !== 1'b0 || wr_oor1 !== 1'b0) begin
            $display("FAIL oor_read_no_flag: got %b/%b, want 0/0", wr_oor0, wr_oor1);
            n_err++;
        end
        wr(12'h02C, 32'hFFFFFFFF, 4'b1111);
        n_vec++;
        if (wr_oor0 !== 1'b1 || wr_oor1 !== 1'b1) begin
            $display("FAIL oor_flag_set: got %b/%b, want 1/1", wr_oor0, wr_oor1);
            n_err++;
        end
        // Word 16 aliases word 0 in the low index bits.
        wr(12'h040, 32'hFFFFFFFF, 4'b1111);
        for (int k = 0; k <= 11; k++) begin
            if (k < 11) begin
                rd_en   = 1'b1;
                rd_addr = 12'(k * 4);
            end else begin
                rd_en = 1'b0;
            end
            step();
            if (k < 11) begin
                n_vec++;
                if ({rd_valid0, rd_data0} !== {1'b1, exp_mem[k]}) begin
                    $display("FAIL oor_unchanged0 w%0d: got v=%b d=%h, want v=1 d=%h",
                             k, rd_valid0, rd_data0, exp_mem[k]);
                    n_err++;
                end
            end
            if (k > 0) begin
                n_vec++;
                if ({rd_valid1, rd_data1} !== {1'b1, exp_mem[k-1]}) begin
                    $display("FAIL oor_unchanged1 w%0d: got v=%b d=%h, want v=1 d=%h",
                             k - 1, rd_valid1, rd_data1, exp_mem[k-1]);
                    n_err++;
                end
            end
        end
        step();
        n_vec++;
        if (wr_oor0 !== 1'b1 || wr_oor1 !== 1'b1) begin
            $display("FAIL oor_flag_sticky: got %b/%b, want 1/1", wr_oor0, wr_oor1);
            n_err++;
        end
    endtask

    task automatic test_reset_mid();
        rd_pulse(12'h008);
        n_vec++;
        if (rd_valid0 !== 1'b1) begin
            $display("FAIL mid_pre_read0: got v=%b, want 1", rd_valid0);
            n_err++;
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({rd_valid0, init_done0, wr_oor0, rd_data0} !== 35'd0 ||
            {rd_valid1, init_done1, wr_oor1, rd_data1} !== 35'd0) begin
            $display("FAIL mid_async_reset: got v=%b/%b id=%b/%b oor=%b/%b, want all 0",
                     rd_valid0, rd_valid1, init_done0, init_done1, wr_oor0, wr_oor1);
            n_err++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_vec++;
            if ({rd_valid0, rd_valid1, init_done0, init_done1} !== 4'b0000) begin
                $display("FAIL mid_flushed cyc %0d: got v=%b/%b id=%b/%b, want all 0",
                         k, rd_valid0, rd_valid1, init_done0, init_done1);
                n_err++;
            end
        end
        // Sweep is now at word 5; interrupt it.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            n_vec++;
            if (init_done0 !== (k == 11) || init_done1 !== (k == 11)) begin
                $display("FAIL mid_restart cyc %0d: got %b/%b, want %b",
                         k, init_done0, init_done1, (k == 11));
                n_err++;
            end
        end
        rd_pulse(12'h004);
        n_vec++;
        if ({rd_valid0, rd_data0, wr_oor0} !== {1'b1, 32'h0, 1'b0}) begin
            $display("FAIL mid_cleared0: got v=%b d=%h oor=%b, want v=1 d=0 oor=0",
                     rd_valid0, rd_data0, wr_oor0);
            n_err++;
        end
        step();
        n_vec++;
        if ({rd_valid1, rd_data1, wr_oor1} !== {1'b1, 32'h0, 1'b0}) begin
            $display("FAIL mid_cleared1: got v=%b d=%h oor=%b, want v=1 d=0 oor=0",
                     rd_valid1, rd_data1, wr_oor1);
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_clear_sweep();
        test_byte_enables();
        test_collision();
        test_streaming();
        test_oor();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
